// File: rtl/sram_1r1w_byp.sv
// One-write/one-read SRAM with lane write masks, a zeroing init sweep after reset,
// and same-address collision flagging. Define SRAM_BYPASS_EN to forward write data on collisions.
module sram_1r1w_byp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int WMASK_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               csb0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               valid1,
  output logic                               collision1,
  output logic                               busy
);

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_en;
  logic                  rd_en;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign busy      = (state == ST_INIT);
  assign wr_en     = (state == ST_RUN) && !csb0;
  assign rd_en     = (state == ST_RUN) && !csb1;
  assign same_addr = wr_en && rd_en && (addr0 == addr1);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_word = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        wr_word[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
  end

  // The read mux sees the merged word only when forwarding is built in.
  always_comb begin
    rd_word = mem[addr1];
`ifdef SRAM_BYPASS_EN
    if (same_addr) begin
      rd_word = wr_word;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      sweep_cnt  <= '0;
      dout1      <= '0;
      valid1     <= 1'b0;
      collision1 <= 1'b0;
    end else begin
      valid1     <= rd_en;
      collision1 <= same_addr;
      if (rd_en) begin
        dout1 <= rd_word;
      end
      if (state == ST_INIT) begin
        sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
        if (sweep_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state <= ST_RUN;
        end
      end
    end
  end

  // NOTE: the array has no reset; its contents come only from the sweep, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= '0;
      end else if (wr_en) begin
        mem[addr0] <= wr_word;
      end
    end
  end

endmodule

// File: doc/sram_1r1w_byp.md
SRAM_1R1W_BYP -- requirements
Module: sram_1r1w_byp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, address width; RAM_DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter WMASK_WIDTH, default 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port csb0, input, 1, active-low write-port select.
REQ-007 The block SHALL have port wmask0, input, NUM_WMASKS, per-lane write enable, 1 = lane written.
REQ-008 The block SHALL have port addr0, input, ADDR_WIDTH, write address.
REQ-009 The block SHALL have port din0, input, DATA_WIDTH, write data.
REQ-010 The block SHALL have port csb1, input, 1, active-low read-port select.
REQ-011 The block SHALL have port addr1, input, ADDR_WIDTH, read address.
REQ-012 The block SHALL have port dout1, output, DATA_WIDTH, registered read data.
REQ-013 The block SHALL have port valid1, output, 1, one-cycle pulse marking new dout1.
REQ-014 The block SHALL have port collision1, output, 1, one-cycle pulse: read and write to the same address accepted on the same edge.
REQ-015 The block SHALL have port busy, output, 1, high while the init sweep runs; both ports are ignored while high.

Function
REQ-016 The FSM SHALL have two states, INIT and RUN; INIT is entered on reset.
REQ-017 In INIT, a counter SHALL write all-zero to address 0, 1, ... RAM_DEPTH-1, one word per cycle; after the RAM_DEPTH-1 write the FSM SHALL go to RUN. busy SHALL be 1 for exactly RAM_DEPTH cycles after rst deasserts.
REQ-018 In RUN with csb0=0 at edge N, lanes of mem[addr0] with wmask0[i]=1 SHALL take din0 lane i; other lanes SHALL be unchanged; wmask0=0 SHALL be a no-op write.
REQ-019 In RUN with csb1=0 at edge N, dout1 SHALL present mem[addr1] and valid1 SHALL be 1 after edge N (latency 1 cycle).
REQ-020 With no read accepted, valid1 SHALL be 0 and dout1 SHALL hold its last value.
REQ-021 Back-to-back reads on every cycle SHALL be supported at full throughput.
REQ-022 For a simultaneous read and write to the same address, collision1 SHALL pulse 1 for one cycle together with valid1; dout1 contents per REQ-028/REQ-029.
REQ-023 Accesses to different addresses on the same edge SHALL not interact.
REQ-024 csb0/csb1 asserted while busy=1 SHALL be dropped: no memory change, no valid1, no collision1.

Reset
REQ-025 When rst=1 at a rising edge: dout1 SHALL be 0, valid1 0, collision1 0, busy 1, counter 0, state INIT.
REQ-026 Reset asserted mid-sweep or mid-RUN SHALL restart the sweep from address 0; any access on that edge SHALL be discarded.
REQ-027 Memory contents SHALL be defined only by the sweep, not directly by rst.

Configuration
REQ-028 With macro SRAM_BYPASS_EN defined, a same-address collision read SHALL return the merged word (din0 in masked lanes, old data elsewhere).
REQ-029 Without SRAM_BYPASS_EN, a same-address collision read SHALL return the pre-write word; collision1 behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset released -> busy=1 for exactly 32 cycles; afterwards reading each of addresses 0..31 gives dout1=0x00000000 with valid1 pulses.
REQ-031 Write addr0=3, din0=0xDEADBEEF, wmask0=4'b1111; next cycle read addr1=3 -> dout1=0xDEADBEEF, valid1=1 one cycle later.
REQ-032 Word 5 = 0x11223344; write din0=0xAABBCCDD with wmask0=4'b0101 -> readback 0x11BB33DD.
REQ-033 Word 7 = 0x00000001; same edge write 0x000000FF with full mask and read addr 7 -> collision1=1; dout1=0x000000FF with SRAM_BYPASS_EN, 0x00000001 without.
REQ-034 Assert rst at sweep count 10, hold one cycle -> busy stays 1 for a further 32 cycles after release; csb1=0 during the sweep -> valid1 stays 0.
REQ-035 Reads to addresses 1, 2, 3 on consecutive edges -> three consecutive valid1 pulses with the matching words in order.
